mips_cpu_lsu_ctrl: RTL and testbench
====================================

// Module: mips_cpu_lsu_ctrl
// PURPOSE
//   Load/store sequencer for the multicycle MIPS core. Accepts one memory op from the core,
//   runs it on the Avalon data bus (waitrequest stall, read data 1 cycle after accept), drives
//   the load-extract mask unit, merges LWL/LWR results and returns one response per request.
//   Sits between the core's MEM stage and the data-bus port; one op outstanding at a time.
// PARAMETERS
//   WAIT_LIMIT  255  max consecutive waitrequest-high cycles in ACCESS before abort; 0 = no limit
// PORTS
//   clk          in   1   clock; single clock domain
//   reset        in   1   synchronous, active-high
//   req_valid    in   1   core presents an op
//   req_ready    out  1   high only in IDLE and reset low; op accepted when req_valid&&req_ready
//   req_op       in   4   0 LW,1 LH,2 LHU,3 LB,4 LBU,5 LWL,6 LWR,8 SW,9 SH,10 SB; others illegal
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data (rt), right-aligned
//   req_rt_old   in   32  current rt value, used by LWL/LWR merge
//   resp_valid   out  1   one-cycle pulse per accepted op
//   resp_rdata   out  32  load result; held until next accept
//   resp_err     out  1   with resp_valid: misaligned, illegal op, or bus timeout
//   address      out  32  {addr[31:2],2'b00}
//   read / write out  1   bus strobes, held while waitrequest high
//   waitrequest  in   1   bus stall
//   writedata    out  32  lane-aligned store data
//   byteenable   out  4   store lanes; 4'b1111 for reads
//   readdata     in   32  valid cycle after read accepted (waitrequest low)
//   msk_cnt      out  3   mask mode: 000 W,001 H signed,010 H unsigned,011 B signed,100 B unsigned,101 LWL,110 LWR
//   msk_cnt2     out  2   byte offset addr[1:0]
//   msk_data     out  32  word to mask unit
//   masked_data  in   32  mask unit result (combinational)
// BEHAVIOUR
//   States: IDLE, ACCESS, RDATA, DONE. Reset -> IDLE; all outputs 0; req_ready 0 while reset high.
//   IDLE: on accept latch op/addr/wdata/rt_old. Illegal op, LH/LHU/SH with a[0]=1, LW/SW with
//     a[1:0]!=0 -> DONE with err=1, no bus access. Else -> ACCESS.
//   ACCESS: read (loads) or write (stores) =1, address/writedata/byteenable stable. Leave on first
//     cycle with waitrequest=0: loads -> RDATA, stores -> DONE. Stall counter (16 b) counts
//     waitrequest-high cycles; when it reaches WAIT_LIMIT (nonzero) strobes drop, -> DONE err=1.
//   RDATA: msk_data=readdata, msk_cnt/msk_cnt2 per op; register result into resp_rdata; -> DONE.
//     Outside RDATA msk_cnt=000, msk_cnt2=00, msk_data=0.
//   LWL merge: m=32'hFFFFFFFF<<(8*(3-a)); result=(masked_data&m)|(rt_old&~m).
//   LWR merge: m=32'hFFFFFFFF>>(8*a); same formula. Other loads: result=masked_data.
//   Stores: SB be=4'b0001<<a, writedata=wdata[7:0]<<8a; SH be=0011/1100, writedata=wdata[15:0]<<16*a[1];
//     SW be=1111, writedata=wdata. resp_rdata unchanged on stores/errors.
//   DONE: resp_valid=1 for exactly one cycle, resp_err as decided; -> IDLE (accept next cycle).
//   Latency from accept edge T, zero wait: load resp_valid at T+3, store T+2, error T+1;
//     each waitrequest-high cycle adds one.
//   read and write never both high; strobes only in ACCESS.
//   Reset mid-op: next edge IDLE, strobes low, no resp_valid, transaction dropped.
// TESTING
//   LB a=0x1003, readdata=0x80FF1234 -> msk 011/11, resp_rdata=0xFFFFFF80, resp_valid at T+3.
//   LWL a=0x2001, readdata=0xAABBCCDD, rt_old=0x11223344 -> resp_rdata=0xCCDD3344.
//   SB a=0x3002, wdata=0x000000A5, waitrequest high 3 cycles -> be=0100, writedata=0x00A50000, write held 4 cycles, resp at T+5.
//   LH a=0x4001 -> no read strobe, resp_err=1 at T+1; then op 7 -> resp_err=1.
//   WAIT_LIMIT=4, waitrequest stuck high on LW -> read drops after 4 stall cycles, resp_err=1.
//   reset pulsed in ACCESS of SW -> write low next cycle, no resp_valid, req_ready high after reset.

Source files
------------

// File: rtl/mips_cpu_lsu_ctrl_if.sv
// rtl/mips_cpu_lsu_ctrl_if.sv - Avalon data-bus port of the load/store sequencer
interface mips_cpu_lsu_ctrl_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic        waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata
   );
endinterface

// File: rtl/mips_cpu_lsu_ctrl.sv
// rtl/mips_cpu_lsu_ctrl.sv - load/store sequencer between the MEM stage and the data bus
module mips_cpu_lsu_ctrl #(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_rt_old,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   mips_cpu_lsu_ctrl_if.master bus,
   output logic [2:0]  msk_cnt,
   output logic [1:0]  msk_cnt2,
   output logic [31:0] msk_data,
   input  logic [31:0] masked_data
);
   typedef enum logic [1:0] {IDLE, ACCESS, RDATA, DONE} state_t;

   localparam logic [3:0]  OP_LW  = 4'd0;
   localparam logic [3:0]  OP_LH  = 4'd1;
   localparam logic [3:0]  OP_LHU = 4'd2;
   localparam logic [3:0]  OP_LB  = 4'd3;
   localparam logic [3:0]  OP_LBU = 4'd4;
   localparam logic [3:0]  OP_LWL = 4'd5;
   localparam logic [3:0]  OP_LWR = 4'd6;
   localparam logic [3:0]  OP_SW  = 4'd8;
   localparam logic [3:0]  OP_SH  = 4'd9;
   localparam logic [3:0]  OP_SB  = 4'd10;
   localparam logic [15:0] LIMIT  = 16'(WAIT_LIMIT);
   localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

   state_t      state, state_nxt;
   logic [3:0]  op_q;
   logic [31:0] addr_q, wdata_q, rt_old_q, rdata_q;
   logic        err_q;
   logic [15:0] stall_cnt;
   logic        accept, req_bad, timeout, is_load;
   logic [4:0]  sh;
   logic [31:0] merge_m, result;

   assign req_ready  = (state == IDLE) && !reset;
   assign accept     = req_valid && req_ready;
   assign is_load    = !op_q[3];
   assign sh         = {addr_q[1:0], 3'b000};
   assign resp_rdata = rdata_q;
   assign timeout    = (LIMIT != 16'd0) && bus.waitrequest && ((stall_cnt + 16'd1) == LIMIT);

   // Classify the offered op: illegal opcodes and misaligned halfword/word accesses never reach the bus.
   always_comb begin
      req_bad = 1'b0;
      case (req_op)
         OP_LW, OP_SW:          req_bad = (req_addr[1:0] != 2'b00);
         OP_LH, OP_LHU, OP_SH:  req_bad = req_addr[0];
         OP_LB, OP_LBU, OP_LWL,
         OP_LWR, OP_SB:         req_bad = 1'b0;
         default:               req_bad = 1'b1;
      endcase
   end

   // Partial-word merge for LWL/LWR; a full mask leaves other loads as the mask unit result.
   always_comb begin
      merge_m = ONES;
      if (op_q == OP_LWL)
         merge_m = ONES << (5'd24 - sh);
      else if (op_q == OP_LWR)
         merge_m = ONES >> sh;
      result = (masked_data & merge_m) | (rt_old_q & ~merge_m);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state plus bus, mask-unit and response strobes; strobes depend only on state so waitrequest never loops back.
   always_comb begin
      state_nxt      = state;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.address    = 32'd0;
      bus.writedata  = 32'd0;
      bus.byteenable = 4'b0000;
      msk_cnt        = 3'b000;
      msk_cnt2       = 2'b00;
      msk_data       = 32'd0;
      resp_valid     = 1'b0;
      resp_err       = 1'b0;
      case (state)
         IDLE: begin
            if (accept)
               state_nxt = req_bad ? DONE : ACCESS;
         end
         ACCESS: begin
            bus.address = {addr_q[31:2], 2'b00};
            bus.read    = is_load;
            bus.write   = !is_load;
            if (is_load) begin
               bus.byteenable = 4'b1111;
            end else if (op_q == OP_SB) begin
               bus.byteenable = 4'b0001 << addr_q[1:0];
               bus.writedata  = {24'd0, wdata_q[7:0]} << sh;
            end else if (op_q == OP_SH) begin
               bus.byteenable = addr_q[1] ? 4'b1100 : 4'b0011;
               bus.writedata  = {16'd0, wdata_q[15:0]} << {addr_q[1], 4'b0000};
            end else begin
               bus.byteenable = 4'b1111;
               bus.writedata  = wdata_q;
            end
            if (!bus.waitrequest)
               state_nxt = is_load ? RDATA : DONE;
            else if (timeout)
               state_nxt = DONE;
         end
         RDATA: begin
            // Mask-mode encoding coincides with the low three bits of the load opcodes.
            msk_cnt   = op_q[2:0];
            msk_cnt2  = addr_q[1:0];
            msk_data  = bus.readdata;
            state_nxt = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Op capture, stall counting, error flag and load result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q      <= 4'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rt_old_q  <= 32'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
         stall_cnt <= 16'd0;
      end else begin
         if (accept) begin
            op_q      <= req_op;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rt_old_q  <= req_rt_old;
            err_q     <= req_bad;
            stall_cnt <= 16'd0;
         end
         if (state == ACCESS && bus.waitrequest) begin
            stall_cnt <= stall_cnt + 16'd1;
            if (timeout)
               err_q <= 1'b1;
         end
         if (state == RDATA)
            rdata_q <= result;
      end
   end
endmodule

// File: tb/tb_mips_cpu_lsu_ctrl.sv
// tb/tb_mips_cpu_lsu_ctrl.sv - scoreboard bench for the load/store sequencer
module tb_mips_cpu_lsu_ctrl;
   localparam int LIM = 4;
   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   typedef struct {
      bit          err;
      logic [31:0] rdata;
      int          lat;
      int          rd_cyc;
      int          wr_cyc;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] addr;
      logic [2:0]  mcnt;
      logic [1:0]  mcnt2;
      bit          both;
      bit          mskbad;
      bit          after_valid;
      bit          after_ready;
   } rec_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rt;
      logic [31:0] rd;
      int          waits;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [31:0] req_rt_old = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [2:0]  msk_cnt;
   logic [1:0]  msk_cnt2;
   logic [31:0] msk_data;
   logic [31:0] masked_data;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model_rdata = 32'd0;
   rec_t        sb[$];

   logic [31:0] mem_word = 32'd0;
   int          wait_cfg = 0;
   bit          stuck = 1'b0;
   int          wait_cnt = 0;
   bit          rd_phase = 1'b0;

   mips_cpu_lsu_ctrl_if bus ();

   mips_cpu_lsu_ctrl #(.WAIT_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .bus(bus),
      .msk_cnt(msk_cnt), .msk_cnt2(msk_cnt2), .msk_data(msk_data),
      .masked_data(masked_data)
   );

   always #5 clk = ~clk;

   // Bus slave: stall each access for wait_cfg cycles (or forever), readdata only in the cycle after a read is taken.
   always @(posedge clk) begin
      wait_cnt <= (bus.read || bus.write) ? wait_cnt + 1 : 0;
      rd_phase <= bus.read && !bus.waitrequest;
   end

   always_comb begin
      bus.waitrequest = (bus.read || bus.write) && (stuck || wait_cnt < wait_cfg);
      bus.readdata    = rd_phase ? mem_word : 32'hDEAD_BEEF;
   end

   // External mask unit: selects and extends the addressed lanes.
   always_comb begin
      masked_data = 32'd0;
      case (msk_cnt)
         3'b000: masked_data = msk_data;
         3'b001: masked_data = msk_cnt2[1] ? {{16{msk_data[31]}}, msk_data[31:16]} : {{16{msk_data[15]}}, msk_data[15:0]};
         3'b010: masked_data = msk_cnt2[1] ? {16'd0, msk_data[31:16]} : {16'd0, msk_data[15:0]};
         3'b011: masked_data = {{24{msk_data[{msk_cnt2, 3'b111}]}}, msk_data[{msk_cnt2, 3'b000} +: 8]};
         3'b100: masked_data = {24'd0, msk_data[{msk_cnt2, 3'b000} +: 8]};
         3'b101: masked_data = msk_data << (5'd24 - {msk_cnt2, 3'b000});
         3'b110: masked_data = msk_data >> {msk_cnt2, 3'b000};
         default: masked_data = 32'd0;
      endcase
   end

   function automatic rec_t model(input logic [3:0] op, input logic [31:0] a, wd, rt, rd,
                                  input int waits, input bit stk);
      rec_t        e;
      bit          bad;
      logic [4:0]  s;
      logic [15:0] h;
      logic [7:0]  b;
      logic [31:0] res;
      e = '{default: 0};
      e.after_ready = 1'b1;
      e.rdata = model_rdata;
      s = {a[1:0], 3'b000};
      case (op)
         4'd0, 4'd8:       bad = (a[1:0] != 2'b00);
         4'd1, 4'd2, 4'd9: bad = a[0];
         4'd3, 4'd4, 4'd5, 4'd6, 4'd10: bad = 1'b0;
         default:          bad = 1'b1;
      endcase
      if (bad) begin
         e.err = 1'b1;
         e.lat = 1;
         return e;
      end
      e.addr = {a[31:2], 2'b00};
      e.be = 4'b1111;
      if (op == 4'd10) begin
         e.be = 4'b0001 << a[1:0];
         e.wd = 32'(wd[7:0]) << s;
      end else if (op == 4'd9) begin
         e.be = a[1] ? 4'b1100 : 4'b0011;
         e.wd = a[1] ? {wd[15:0], 16'd0} : {16'd0, wd[15:0]};
      end else if (op == 4'd8) begin
         e.wd = wd;
      end
      if (stk || waits >= LIM) begin
         e.err = 1'b1;
         e.lat = LIM + 1;
         if (op[3]) e.wr_cyc = LIM; else e.rd_cyc = LIM;
         return e;
      end
      if (op[3]) begin
         e.lat = 2 + waits;
         e.wr_cyc = 1 + waits;
         return e;
      end
      e.lat = 3 + waits;
      e.rd_cyc = 1 + waits;
      e.mcnt2 = a[1:0];
      h = a[1] ? rd[31:16] : rd[15:0];
      b = rd[s +: 8];
      case (op)
         4'd1:    begin res = {{16{h[15]}}, h}; e.mcnt = 3'b001; end
         4'd2:    begin res = {16'd0, h};       e.mcnt = 3'b010; end
         4'd3:    begin res = {{24{b[7]}}, b};  e.mcnt = 3'b011; end
         4'd4:    begin res = {24'd0, b};       e.mcnt = 3'b100; end
         4'd5:    begin res = (rd << (5'd24 - s)) | (rt & ~(ONES << (5'd24 - s))); e.mcnt = 3'b101; end
         4'd6:    begin res = (rd >> s) | (rt & ~(ONES >> s)); e.mcnt = 3'b110; end
         default: begin res = rd;               e.mcnt = 3'b000; end
      endcase
      e.rdata = res;
      model_rdata = res;
      return e;
   endfunction

   // Drives one op (caller is just past a negedge), observes the bus until resp_valid, then one more cycle.
   task automatic run_op(input vec_t v, input bit stk, output rec_t o);
      bit prev_rd;
      int n;
      o = '{default: 0};
      o.lat = -1;
      mem_word = v.rd;
      wait_cfg = v.waits;
      stuck = stk;
      req_op = v.op;
      req_addr = v.a;
      req_wdata = v.wd;
      req_rt_old = v.rt;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      prev_rd = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (bus.read && bus.write) o.both = 1'b1;
         if (bus.read) o.rd_cyc++;
         if (bus.write) o.wr_cyc++;
         if (bus.read || bus.write) begin
            o.addr = bus.address;
            o.be = bus.byteenable;
            if (bus.write) o.wd = bus.writedata;
         end
         if (prev_rd && !bus.read) begin
            o.mcnt = msk_cnt;
            o.mcnt2 = msk_cnt2;
         end else if (msk_cnt != 3'b000 || msk_cnt2 != 2'b00 || msk_data != 32'd0) begin
            o.mskbad = 1'b1;
         end
         prev_rd = bus.read;
         if (resp_valid) begin
            o.lat = k;
            o.err = resp_err;
            o.rdata = resp_rdata;
            break;
         end
      end
      @(negedge clk);
      o.after_valid = resp_valid;
      o.after_ready = req_ready;
      stuck = 1'b0;
   endtask

   task automatic test_reset();
      req_valid = 1'b1;
      req_op = 4'd0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || bus.read !== 1'b0 || bus.write !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_strobes: ready=%b valid=%b rd=%b wr=%b required all 0", req_ready, resp_valid, bus.read, bus.write);
      end
      vectors++;
      if (resp_rdata !== 32'd0 || resp_err !== 1'b0 || msk_cnt !== 3'b000 || msk_data !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: rdata=%h err=%b mcnt=%b mdata=%h required zeros", resp_rdata, resp_err, msk_cnt, msk_data);
      end
      req_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready: got %b required 1", req_ready);
      end
   endtask

   task automatic test_loads();
      vec_t v[8];
      rec_t e, o;
      v[0] = '{4'd3, 32'h0000_1003, 32'd0, 32'd0,           32'h80FF_1234, 0};
      v[1] = '{4'd5, 32'h0000_2001, 32'd0, 32'h1122_3344,   32'hAABB_CCDD, 0};
      v[2] = '{4'd0, 32'h0000_5000, 32'd0, 32'd0,           32'h1234_5678, 2};
      v[3] = '{4'd1, 32'h0000_5002, 32'd0, 32'd0,           32'h8001_7FFF, 0};
      v[4] = '{4'd2, 32'h0000_5002, 32'd0, 32'd0,           32'h8001_7FFF, 1};
      v[5] = '{4'd4, 32'h0000_5001, 32'd0, 32'd0,           32'h1234_F600, 0};
      v[6] = '{4'd6, 32'h0000_6002, 32'd0, 32'h1122_3344,   32'hAABB_CCDD, 0};
      v[7] = '{4'd5, 32'h0000_6003, 32'd0, 32'h1122_3344,   32'hAABB_CCDD, 3};
      for (int i = 0; i < 8; i++) begin
         sb.push_back(model(v[i].op, v[i].a, v[i].wd, v[i].rt, v[i].rd, v[i].waits, 1'b0));
         run_op(v[i], 1'b0, o);
         e = sb.pop_front();
         vectors++;
         if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
            miscompares++;
            $display("FAIL load[%0d]_resp: rdata=%h err=%b lat=%0d required %h %b %0d", i, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
         end
         vectors++;
         if (o.rd_cyc != e.rd_cyc || o.wr_cyc != 0 || o.addr !== e.addr || o.be !== 4'b1111 || o.both) begin
            miscompares++;
            $display("FAIL load[%0d]_bus: rd=%0d wr=%0d addr=%h be=%b required %0d 0 %h 1111", i, o.rd_cyc, o.wr_cyc, o.addr, o.be, e.rd_cyc, e.addr);
         end
         vectors++;
         if (o.mcnt !== e.mcnt || o.mcnt2 !== e.mcnt2 || o.mskbad || o.after_valid) begin
            miscompares++;
            $display("FAIL load[%0d]_mask: cnt=%b cnt2=%b stray=%b vld_after=%b required %b %b 0 0", i, o.mcnt, o.mcnt2, o.mskbad, o.after_valid, e.mcnt, e.mcnt2);
         end
         if (i == 0) begin
            vectors++;
            if (o.rdata !== 32'hFFFF_FF80 || o.lat != 3 || o.mcnt !== 3'b011 || o.mcnt2 !== 2'b11) begin
               miscompares++;
               $display("FAIL lb_example: rdata=%h lat=%0d msk=%b/%b required ffffff80 3 011/11", o.rdata, o.lat, o.mcnt, o.mcnt2);
            end
         end
         if (i == 1) begin
            vectors++;
            if (o.rdata !== 32'hCCDD_3344) begin
               miscompares++;
               $display("FAIL lwl_example: rdata=%h required ccdd3344", o.rdata);
            end
         end
      end
   endtask

   task automatic test_stores();
      vec_t v[5];
      rec_t e, o;
      v[0] = '{4'd10, 32'h0000_3002, 32'h0000_00A5, 32'd0, 32'd0, 3};
      v[1] = '{4'd9,  32'h0000_3002, 32'h1234_BEEF, 32'd0, 32'd0, 0};
      v[2] = '{4'd9,  32'h0000_3000, 32'h1234_BEEF, 32'd0, 32'd0, 1};
      v[3] = '{4'd8,  32'h0000_3004, 32'hCAFE_F00D, 32'd0, 32'd0, 1};
      v[4] = '{4'd10, 32'h0000_3001, 32'hFFFF_FF5A, 32'd0, 32'd0, 0};
      for (int i = 0; i < 5; i++) begin
         sb.push_back(model(v[i].op, v[i].a, v[i].wd, v[i].rt, v[i].rd, v[i].waits, 1'b0));
         run_op(v[i], 1'b0, o);
         e = sb.pop_front();
         vectors++;
         if (o.be !== e.be || o.wd !== e.wd || o.addr !== e.addr) begin
            miscompares++;
            $display("FAIL store[%0d]_lanes: be=%b wd=%h addr=%h required %b %h %h", i, o.be, o.wd, o.addr, e.be, e.wd, e.addr);
         end
         vectors++;
         if (o.lat != e.lat || o.wr_cyc != e.wr_cyc || o.rd_cyc != 0 || o.err !== 1'b0 || o.rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL store[%0d]_resp: lat=%0d wr=%0d rd=%0d err=%b rdata=%h required %0d %0d 0 0 %h", i, o.lat, o.wr_cyc, o.rd_cyc, o.err, o.rdata, e.lat, e.wr_cyc, e.rdata);
         end
         if (i == 0) begin
            vectors++;
            if (o.be !== 4'b0100 || o.wd !== 32'h00A5_0000 || o.wr_cyc != 4 || o.lat != 5) begin
               miscompares++;
               $display("FAIL sb_example: be=%b wd=%h wr=%0d lat=%0d required 0100 00a50000 4 5", o.be, o.wd, o.wr_cyc, o.lat);
            end
         end
      end
   endtask

   task automatic test_errors();
      vec_t v[7];
      rec_t e, o;
      v[0] = '{4'd1,  32'h0000_4001, 32'd0, 32'd0, 32'h1111_1111, 0};
      v[1] = '{4'd7,  32'h0000_4000, 32'd0, 32'd0, 32'h1111_1111, 0};
      v[2] = '{4'd8,  32'h0000_4002, 32'd1, 32'd0, 32'h1111_1111, 0};
      v[3] = '{4'd0,  32'h0000_4003, 32'd0, 32'd0, 32'h1111_1111, 0};
      v[4] = '{4'd9,  32'h0000_4001, 32'd1, 32'd0, 32'h1111_1111, 0};
      v[5] = '{4'd2,  32'h0000_4003, 32'd0, 32'd0, 32'h1111_1111, 0};
      v[6] = '{4'd15, 32'h0000_4000, 32'd0, 32'd0, 32'h1111_1111, 0};
      for (int i = 0; i < 7; i++) begin
         sb.push_back(model(v[i].op, v[i].a, v[i].wd, v[i].rt, v[i].rd, v[i].waits, 1'b0));
         run_op(v[i], 1'b0, o);
         e = sb.pop_front();
         vectors++;
         if (o.err !== e.err || o.lat != e.lat || o.rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL error[%0d]_resp: err=%b lat=%0d rdata=%h required %b %0d %h", i, o.err, o.lat, o.rdata, e.err, e.lat, e.rdata);
         end
         vectors++;
         if (o.rd_cyc != 0 || o.wr_cyc != 0 || o.after_ready !== e.after_ready || o.after_valid) begin
            miscompares++;
            $display("FAIL error[%0d]_nobus: rd=%0d wr=%0d ready_after=%b vld_after=%b required 0 0 1 0", i, o.rd_cyc, o.wr_cyc, o.after_ready, o.after_valid);
         end
      end
   endtask

   task automatic test_timeout();
      vec_t v;
      rec_t e, o;
      for (int i = 0; i < 3; i++) begin
         v = '{(i == 1) ? 4'd8 : 4'd0, 32'h0000_7000 + 32'(i * 4), 32'h0BAD_0BAD, 32'd0, 32'h5555_AAAA, (i == 2) ? LIM : 0};
         sb.push_back(model(v.op, v.a, v.wd, v.rt, v.rd, v.waits, i != 2));
         run_op(v, i != 2, o);
         e = sb.pop_front();
         vectors++;
         if (o.err !== 1'b1 || o.err !== e.err || o.lat != e.lat || o.rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL timeout[%0d]_resp: err=%b lat=%0d rdata=%h required 1 %0d %h", i, o.err, o.lat, o.rdata, e.lat, e.rdata);
         end
         vectors++;
         if (o.rd_cyc != e.rd_cyc || o.wr_cyc != e.wr_cyc || o.mskbad || o.after_valid) begin
            miscompares++;
            $display("FAIL timeout[%0d]_strobes: rd=%0d wr=%0d stray=%b vld_after=%b required %0d %0d 0 0", i, o.rd_cyc, o.wr_cyc, o.mskbad, o.after_valid, e.rd_cyc, e.wr_cyc);
         end
      end
   endtask

   task automatic test_back_to_back();
      vec_t v;
      rec_t e, o;
      for (int i = 0; i < 10; i++) begin
         v.op = (i % 5 == 3) ? 4'd13 : 4'($urandom_range(0, 6) + ((i % 2) ? 8 : 0));
         if (v.op == 4'd11 || v.op == 4'd12 || v.op == 4'd13 || v.op == 4'd14) v.op = 4'd10;
         if (i % 5 == 3) v.op = 4'd13;
         v.a = {16'h0000, 16'($urandom_range(0, 16'hFFFF))};
         if (v.op == 4'd0 || v.op == 4'd8) v.a[1:0] = 2'b00;
         if (v.op == 4'd1 || v.op == 4'd2 || v.op == 4'd9) v.a[0] = 1'b0;
         v.wd = $urandom;
         v.rt = $urandom;
         v.rd = $urandom;
         v.waits = $urandom_range(0, 2);
         sb.push_back(model(v.op, v.a, v.wd, v.rt, v.rd, v.waits, 1'b0));
         run_op(v, 1'b0, o);
         e = sb.pop_front();
         vectors++;
         if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat || o.both || o.after_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b[%0d] op%0d: rdata=%h err=%b lat=%0d both=%b ready_after=%b required %h %b %0d 0 1", i, v.op, o.rdata, o.err, o.lat, o.both, o.after_ready, e.rdata, e.err, e.lat);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      vec_t v;
      rec_t e, o;
      bit   seen;
      stuck = 1'b1;
      req_op = 4'd8;
      req_addr = 32'h0000_8000;
      req_wdata = 32'h1357_9BDF;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.write !== 1'b1) begin
         miscompares++;
         $display("FAIL midop_write_active: got %b required 1", bus.write);
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.write !== 1'b0 || bus.read !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_reset: wr=%b rd=%b vld=%b ready=%b required 0 0 0 0", bus.write, bus.read, resp_valid, req_ready);
      end
      reset = 1'b0;
      stuck = 1'b0;
      model_rdata = 32'd0;
      seen = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midop_ready_after: got %b required 1", req_ready);
      end
      for (int k = 0; k < 6; k++) begin
         if (resp_valid) seen = 1'b1;
         @(negedge clk);
      end
      vectors++;
      if (seen) begin
         miscompares++;
         $display("FAIL midop_dropped: resp_valid seen=%b required 0", seen);
      end
      v = '{4'd4, 32'h0000_9002, 32'd0, 32'd0, 32'h00C3_0000, 0};
      sb.push_back(model(v.op, v.a, v.wd, v.rt, v.rd, v.waits, 1'b0));
      run_op(v, 1'b0, o);
      e = sb.pop_front();
      vectors++;
      if (o.rdata !== e.rdata || o.lat != e.lat || o.err !== e.err) begin
         miscompares++;
         $display("FAIL midop_recover: rdata=%h lat=%0d err=%b required %h %0d %b", o.rdata, o.lat, o.err, e.rdata, e.lat, e.err);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_timeout();
      test_back_to_back();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
